// File: rtl/led_framebuffer_if.sv
// Host/scan bus of the LED framebuffer: scan read port, pixel write
// channel and buffer-control strobes.
interface led_framebuffer_if #(
    parameter int COLOR_BITS = 24
);
    logic [5:0]            addrx;
    logic [4:0]            addry;
    logic [COLOR_BITS-1:0] data0;
    logic [COLOR_BITS-1:0] data1;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [5:0]            wr_x;
    logic [5:0]            wr_y;
    logic [COLOR_BITS-1:0] wr_data;
    logic                  swap_req;
    logic                  clear_req;
    logic                  swap_done;
    logic                  busy;

    modport master (
        output addrx, addry, wr_valid, wr_x, wr_y, wr_data, swap_req, clear_req,
        input  data0, data1, wr_ready, swap_done, busy
    );

    modport slave (
        input  addrx, addry, wr_valid, wr_x, wr_y, wr_data, swap_req, clear_req,
        output data0, data1, wr_ready, swap_done, busy
    );
endinterface

// File: rtl/led_framebuffer.sv
// Double-buffered 64x64 RGB framebuffer for a two-half LED panel.
// The scan side reads the front bank; the host writes or clears the back
// bank, and swaps are deferred to the end of a frame so the display never
// tears.
module led_framebuffer #(
    parameter int                    COLOR_BITS  = 24,
    parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
    input logic               clk,
    input logic               reset,
    led_framebuffer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

    // Index = {bank, row[4:0], col[5:0]}; top holds rows 0..31, bot rows 32..63.
    logic [COLOR_BITS-1:0] mem_top [0:4095];
    logic [COLOR_BITS-1:0] mem_bot [0:4095];

    state_t                state, state_nxt;
    logic                  swap_pend, pend_nxt;
    logic [10:0]           clr_cnt;
    logic                  front_sel;
    logic                  do_swap;
    logic                  eof;
    logic                  wr_ready;
    logic                  wr_accept;
    logic                  clr_we;
    logic                  top_we, bot_we;
    logic [11:0]           wr_addr;
    logic [COLOR_BITS-1:0] wr_word;

    assign eof       = (bus.addrx == 6'd63) && (bus.addry == 5'd31);
    assign wr_ready  = (state == IDLE) && !reset;
    assign wr_accept = bus.wr_valid && wr_ready;
    assign clr_we    = (state == CLEAR) && !reset;

    // A clear writes the same word to both halves; a host write hits one half.
    assign top_we  = clr_we || (wr_accept && !bus.wr_y[5]);
    assign bot_we  = clr_we || (wr_accept &&  bus.wr_y[5]);
    assign wr_addr = clr_we ? {~front_sel, clr_cnt}
                            : {~front_sel, bus.wr_y[4:0], bus.wr_x};
    assign wr_word = clr_we ? CLEAR_COLOR : bus.wr_data;

    assign bus.wr_ready = wr_ready;
    assign bus.busy     = (state != IDLE);

    // Next-state logic; a swap requested during a clear is remembered in swap_pend.
    always_comb begin
        state_nxt = state;
        pend_nxt  = swap_pend;
        do_swap   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_nxt = CLEAR;
                    pend_nxt  = bus.swap_req;
                end else if (bus.swap_req) begin
                    state_nxt = SWAP_WAIT;
                end
            end
            CLEAR: begin
                if (bus.swap_req) pend_nxt = 1'b1;
                if (clr_cnt == 11'd2047) begin
                    if (swap_pend || bus.swap_req) begin
                        state_nxt = SWAP_WAIT;
                        pend_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SWAP_WAIT: begin
                if (eof) begin
                    state_nxt = IDLE;
                    do_swap   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers: state, pending swap, clear counter, bank select, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            swap_pend <= 1'b0;
            clr_cnt   <= '0;
            front_sel <= 1'b0;
            bus.swap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            swap_pend <= pend_nxt;
            clr_cnt   <= (state == CLEAR) ? clr_cnt + 11'd1 : 11'd0;
            if (do_swap) front_sel <= ~front_sel;
            bus.swap_done <= do_swap;
        end
    end

    // Back-bank write port; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (top_we) mem_top[wr_addr] <= wr_word;
        if (bot_we) mem_bot[wr_addr] <= wr_word;
    end

    // Registered scan read from the bank that is front in the address cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data0 <= '0;
            bus.data1 <= '0;
        end else begin
            bus.data0 <= mem_top[{front_sel, bus.addry, bus.addrx}];
            bus.data1 <= mem_bot[{front_sel, bus.addry, bus.addrx}];
        end
    end
endmodule

// File: tb/tb_led_framebuffer.sv
// Bench for led_framebuffer: a frame-level model (two 64x64 pixel arrays,
// a remaining-clear count and a "swap wanted" flag) predicts every cycle's
// outputs; a monitor pops the predictions and compares them with the DUT.
module tb_led_framebuffer;
    localparam logic [23:0] CC = 24'h123456;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_framebuffer_if #(.COLOR_BITS(24)) bus ();
    led_framebuffer #(.COLOR_BITS(24), .CLEAR_COLOR(CC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        int          c;
        logic        chk0, chk1;
        logic [23:0] d0, d1;
        logic        busy, rdy, sd;
    } rec_t;

    rec_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   sd_seen  = 0;

    // Frame-level model state
    logic [23:0] fb [2][64][64];
    bit          kn [2][64][64];
    bit          front;
    int          clear_left;
    bit          swap_wanted;
    bit          sd_q;
    logic [23:0] rd0_q, rd1_q;
    bit          rk0, rk1;
    logic [5:0]  sx;
    logic [4:0]  sy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [23:0] act, logic [23:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT outputs against predictions for this cycle
    always @(negedge clk) begin
        rec_t r;
        while (q.size() > 0 && q[0].c <= cyc) begin
            r = q.pop_front();
            chk("busy",      {23'd0, bus.busy},      {23'd0, r.busy});
            chk("wr_ready",  {23'd0, bus.wr_ready},  {23'd0, r.rdy});
            chk("swap_done", {23'd0, bus.swap_done}, {23'd0, r.sd});
            if (r.chk0) chk("data0", bus.data0, r.d0);
            if (r.chk1) chk("data1", bus.data1, r.d1);
        end
    end

    function automatic bit model_idle();
        return (clear_left == 0) && !swap_wanted;
    endfunction

    // One clock cycle: inputs are already on the bus; predict, advance model, clock.
    task automatic step();
        rec_t r;
        bit   idle;
        int   k, bk;
        idle   = model_idle();
        r.c    = cyc;
        r.chk0 = rk0;  r.chk1 = rk1;
        r.d0   = rd0_q; r.d1  = rd1_q;
        r.busy = !idle;
        r.rdy  = idle && !reset;
        r.sd   = sd_q;
        q.push_back(r);
        if (bus.swap_done === 1'b1) sd_seen++;

        bk    = front ? 1 : 0;
        rk0   = kn[bk][int'(bus.addry)][bus.addrx];
        rd0_q = fb[bk][int'(bus.addry)][bus.addrx];
        rk1   = kn[bk][int'(bus.addry) + 32][bus.addrx];
        rd1_q = fb[bk][int'(bus.addry) + 32][bus.addrx];
        sd_q  = 1'b0;
        bk    = front ? 0 : 1;

        if (reset) begin
            front = 1'b0; clear_left = 0; swap_wanted = 1'b0;
            rd0_q = '0; rd1_q = '0; rk0 = 1'b1; rk1 = 1'b1;
        end else if (idle) begin
            if (bus.wr_valid) begin
                fb[bk][bus.wr_y][bus.wr_x] = bus.wr_data;
                kn[bk][bus.wr_y][bus.wr_x] = 1'b1;
            end
            if (bus.clear_req) begin
                clear_left  = 2048;
                swap_wanted = bus.swap_req;
            end else if (bus.swap_req) begin
                swap_wanted = 1'b1;
            end
        end else if (clear_left > 0) begin
            k = 2048 - clear_left;
            fb[bk][k / 64][k % 64]      = CC;  kn[bk][k / 64][k % 64]      = 1'b1;
            fb[bk][k / 64 + 32][k % 64] = CC;  kn[bk][k / 64 + 32][k % 64] = 1'b1;
            clear_left--;
            if (bus.swap_req) swap_wanted = 1'b1;
        end else if (bus.addrx == 6'd63 && bus.addry == 5'd31) begin
            front       = !front;
            swap_wanted = 1'b0;
            sd_q        = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.wr_valid  = 1'b0;
        bus.swap_req  = 1'b0;
        bus.clear_req = 1'b0;
        bus.wr_x      = 6'($urandom);
        bus.wr_y      = 6'($urandom);
        bus.wr_data   = 24'($urandom);
    endtask

    task automatic scan();
        bus.addrx = sx;
        bus.addry = sy;
        {sy, sx}  = {sy, sx} + 11'd1;
    endtask

    task automatic run(int n, bit wv_hold);
        for (int i = 0; i < n; i++) begin
            quiet_inputs();
            bus.wr_valid = wv_hold;
            scan();
            step();
        end
    endtask

    task automatic pulse(bit sw, bit cl);
        quiet_inputs();
        bus.swap_req  = sw;
        bus.clear_req = cl;
        scan();
        step();
    endtask

    task automatic wait_idle(int limit);
        int i = 0;
        while (!model_idle() && i < limit) begin
            run(1, 1'b0);
            i++;
        end
        n_assert++;
        if (!model_idle()) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
        end
    endtask

    initial begin
        reset = 1'b1;
        sx = '0; sy = '0;
        quiet_inputs();
        bus.addrx = '0; bus.addry = '0;
        repeat (3) @(posedge clk);
        #1;
        front = 1'b0; clear_left = 0; swap_wanted = 1'b0; sd_q = 1'b0;
        rd0_q = '0; rd1_q = '0; rk0 = 1'b1; rk1 = 1'b1;
        run(2, 1'b0);                       // reset cycles: busy 0, wr_ready 0, data 0
        reset = 1'b0;
        run(3, 1'b0);

        // Fill both banks with CLEAR_COLOR; wr_valid held during the second clear
        pulse(1'b0, 1'b1);
        wait_idle(2100);
        pulse(1'b1, 1'b0);
        wait_idle(2100);
        pulse(1'b0, 1'b1);
        run(2052, 1'b1);
        wait_idle(10);
        pulse(1'b1, 1'b0);
        wait_idle(2100);
        run(2048, 1'b0);                    // full-frame read of the cleared bank

        // Single pixel write, swap, read it back through data1
        quiet_inputs();
        bus.wr_valid = 1'b1; bus.wr_x = 6'd5; bus.wr_y = 6'd40; bus.wr_data = 24'h00FF00;
        scan();
        step();
        sd_seen = 0;
        pulse(1'b1, 1'b0);
        wait_idle(2100);
        run(2, 1'b0);
        chk("swap_done_count_single", 24'(sd_seen), 24'd1);
        quiet_inputs();
        bus.addrx = 6'd5; bus.addry = 5'd8;
        step();
        chk("pixel_5_40", bus.data1, 24'h00FF00);

        // Swap and clear in the same cycle: clear first, then exactly one swap
        sd_seen = 0;
        pulse(1'b1, 1'b1);
        wait_idle(4300);
        run(2, 1'b0);
        chk("swap_done_count_clear_swap", 24'(sd_seen), 24'd1);

        // Reset in the middle of a clear
        sd_seen = 0;
        pulse(1'b1, 1'b1);
        run(1000, 1'b0);
        reset = 1'b1;
        run(1, 1'b0);
        reset = 1'b0;
        run(3000, 1'b0);
        chk("swap_done_after_abort", 24'(sd_seen), 24'd0);

        // Randomized traffic
        for (int i = 0; i < 15000; i++) begin
            quiet_inputs();
            bus.wr_valid  = ($urandom % 2) == 0;
            bus.swap_req  = ($urandom % 200) == 0;
            bus.clear_req = ($urandom % 1500) == 0;
            reset         = ($urandom % 4000) == 0;
            if ((($urandom % 5) == 0) && ({sy, sx} != 11'h7FF)) begin
                bus.addrx = 6'($urandom);
                bus.addry = 5'($urandom);
                {sy, sx}  = {sy, sx} + 11'd1;
            end else begin
                scan();
            end
            step();
        end
        reset = 1'b0;
        run(4, 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
